alu_result_tx: RTL and testbench

Serial transmitter that returns ALU results from the FPGA to the external microcontroller, the reverse path of the uC-to-FPGA control lines that drive the ALU bring-up top. On a send request it captures the ALU result word and flag nibble, appends an even-parity bit, and shifts the frame out MSB-first on a clock/data/frame interface. It then waits for an acknowledge from the uC, with a timeout. It sits beside the ALU result and flag registers.

---
 rtl/alu_result_tx.sv | 163 ++++++++++++++++
 tb/tb_alu_result_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_tx.sv
// alu_result_tx
// Serial transmitter that returns ALU results to the external microcontroller.
// On a send request it captures the result word and flag nibble and appends an
// even-parity bit. It then shifts the frame out MSB-first on sclk/sdata/frame
// and waits for an acknowledge from the uC, with a timeout.
//
// Ports
//   clk_i     system clock (only clock)
//   reset_ni  asynchronous active-low reset
//   send_i    transmit request, sampled only in IDLE
//   data_i    ALU result word, captured at accept
//   flags_i   ALU flag field, captured at accept
//   ack_i     uC acknowledge, sampled only in ACK
//   sclk_o    serial clock; the uC samples sdata_o on its rising edge
//   sdata_o   serial data
//   frame_o   high for the whole frame plus the ACK wait
//   busy_o    high whenever the FSM is not IDLE
//   done_o    one-cycle pulse on acknowledged completion
//   err_o     one-cycle pulse on ACK timeout
//   state_o   current FSM state (IDLE=0, LOW=1, HIGH=2, ACK=3) for debug
//
// Handshake: send_i is a valid with implicit ready = !busy_o. A request is
// taken on any edge where the FSM is IDLE and send_i=1. Requests made while
// busy are dropped, not queued. ack_i is a level sampled only while waiting in
// ACK. Outside ACK it has no effect.

module alu_result_tx #(
  parameter int DATA_WIDTH  = 16,
  parameter int FLAG_SIZE   = 4,
  parameter int HALF        = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  send_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [FLAG_SIZE-1:0]  flags_i,
  input  logic                  ack_i,
  output logic                  sclk_o,
  output logic                  sdata_o,
  output logic                  frame_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            state_o
);

  localparam int N  = FLAG_SIZE + DATA_WIDTH + 1;
  localparam int BW = $clog2(N);

  // Counters run from value-1 down to 0, so a phase lasts exactly HALF cycles.
  localparam logic [7:0]    HALF_M1  = 8'(HALF - 1);
  localparam logic [15:0]   TO_M1    = 16'(ACK_TIMEOUT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t          state;
  logic [N-1:0]    shreg;
  logic [BW-1:0]   bit_cnt;
  logic [7:0]      half_cnt;
  logic [15:0]     to_cnt;
  logic [N-1:0]    frame_word;

  // Even parity: the complete frame always contains an even number of ones.
  assign frame_word = {flags_i, data_i, ^{flags_i, data_i}};
  assign state_o    = state;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      half_cnt <= '0;
      to_cnt   <= '0;
      sclk_o   <= 1'b0;
      sdata_o  <= 1'b0;
      frame_o  <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (send_i) begin
            shreg    <= frame_word;
            bit_cnt  <= '0;
            half_cnt <= HALF_M1;
            sclk_o   <= 1'b0;
            sdata_o  <= frame_word[N-1];
            frame_o  <= 1'b1;
            busy_o   <= 1'b1;
            state    <= LOW;
          end
        end

        LOW: begin
          if (half_cnt == 8'd0) begin
            half_cnt <= HALF_M1;
            sclk_o   <= 1'b1;
            state    <= HIGH;
          end else begin
            half_cnt <= half_cnt - 8'd1;
          end
        end

        HIGH: begin
          if (half_cnt == 8'd0) begin
            half_cnt <= HALF_M1;
            sclk_o   <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              sdata_o <= 1'b0;
              to_cnt  <= '0;
              state   <= ACK;
            end else begin
              // Next bit goes out with the falling sclk edge, so it has a full
              // half-period of setup before the following rise.
              shreg   <= shreg << 1;
              sdata_o <= shreg[N-2];
              bit_cnt <= bit_cnt + BW'(1);
              state   <= LOW;
            end
          end else begin
            half_cnt <= half_cnt - 8'd1;
          end
        end

        ACK: begin
          // ack_i is tested first so it wins over a coincident timeout.
          if (ack_i) begin
            done_o  <= 1'b1;
            frame_o <= 1'b0;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end else if (to_cnt == TO_M1) begin
            err_o   <= 1'b1;
            frame_o <= 1'b0;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end

        default: begin
          state   <= IDLE;
          sclk_o  <= 1'b0;
          sdata_o <= 1'b0;
          frame_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_tx.sv
module tb_alu_result_tx;

  localparam int DW     = 16;
  localparam int FW     = 4;
  localparam int HALF   = 2;
  localparam int ACK_TO = 8;
  localparam int N      = FW + DW + 1;
  localparam int BITS_CYCLES = 2 * HALF * N;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_ni;
  logic          send_i;
  logic [DW-1:0] data_i;
  logic [FW-1:0] flags_i;
  logic          ack_i;
  logic          sclk_o, sdata_o, frame_o, busy_o, done_o, err_o;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  alu_result_tx #(
    .DATA_WIDTH (DW),
    .FLAG_SIZE  (FW),
    .HALF       (HALF),
    .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk_i   (clk),
    .reset_ni(reset_ni),
    .send_i  (send_i),
    .data_i  (data_i),
    .flags_i (flags_i),
    .ack_i   (ack_i),
    .sclk_o  (sclk_o),
    .sdata_o (sdata_o),
    .frame_o (frame_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .state_o (state_o)
  );

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];
  int           exp_len_q[$];
  bit           exp_err_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a frame is flags, data, then a parity bit that makes the
  // number of ones even. Its length is the bit time plus the ACK wait.
  task automatic push_expect(input logic [DW-1:0] d, input logic [FW-1:0] f,
                             input int ack_at);
    int ones;
    logic par;
    ones = $countones({f, d});
    par  = ((ones % 2) == 1);
    exp_q.push_back({f, d, par});
    exp_len_q.push_back(BITS_CYCLES + ((ack_at == 0) ? ACK_TO : ack_at));
    exp_err_q.push_back(ack_at == 0);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at the negedge of the
  // done/err cycle. ack_at = edge number within ACK at which ack_i is seen
  // (1..ACK_TO), 0 = never acknowledge.
  task automatic send_frame(input logic [DW-1:0] d, input logic [FW-1:0] f,
                            input int ack_at, input bit noise);
    int total;
    push_expect(d, f, ack_at);
    total   = BITS_CYCLES + ((ack_at == 0) ? ACK_TO : ack_at);
    send_i  = 1'b1;
    data_i  = d;
    flags_i = f;
    ack_i   = 1'b0;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (noise && c <= BITS_CYCLES) begin
        send_i  = 1'($urandom_range(0, 1));
        data_i  = ($urandom_range(0, 1) == 1) ? 16'h1234 : DW'($urandom);
        flags_i = FW'($urandom);
        ack_i   = 1'($urandom_range(0, 1));
      end else begin
        send_i = 1'b0;
        ack_i  = (ack_at != 0) && (c == BITS_CYCLES + ack_at);
      end
    end
    @(negedge clk);
    ack_i  = 1'b0;
    send_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_i  = DW'($urandom);
      flags_i = FW'($urandom);
      ack_i   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    ack_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sclk"},  longint'(sclk_o),  0);
    check({tag, "_sdata"}, longint'(sdata_o), 0);
    check({tag, "_frame"}, longint'(frame_o), 0);
    check({tag, "_busy"},  longint'(busy_o),  0);
    check({tag, "_done"},  longint'(done_o),  0);
    check({tag, "_err"},   longint'(err_o),   0);
    check({tag, "_state"}, longint'(state_o), 0);
  endtask

  // Start a frame, then pull reset low during bit 5; that frame is abandoned.
  task automatic reset_mid_frame();
    send_i  = 1'b1;
    data_i  = DW'($urandom);
    flags_i = FW'($urandom);
    for (int c = 1; c <= 2 * HALF * 5 + 1; c++) begin
      @(negedge clk);
      send_i = 1'b0;
    end
    #2 reset_ni = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    #2 reset_ni = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  logic         prev_frame = 1'b0;
  logic         prev_sclk  = 1'b0;
  logic [N-1:0] got_bits;
  int           nbits, flen, run;
  logic         ref_bit, hi_bit, hold_bad;

  always @(negedge clk) begin
    if (!reset_ni) begin
      prev_frame = 1'b0;
      prev_sclk  = 1'b0;
    end else begin
      if (frame_o) begin
        if (!prev_frame) begin
          got_bits = '0;
          nbits    = 0;
          flen     = 0;
          run      = 0;
          ref_bit  = sdata_o;
          hold_bad = 1'b0;
        end
        flen++;
        if (sclk_o != prev_sclk) begin
          if (sclk_o) begin
            check("low_phase_len", run, HALF);
            check("setup_stable", longint'(sdata_o), longint'(ref_bit));
            got_bits = {got_bits[N-2:0], sdata_o};
            nbits++;
            hi_bit = sdata_o;
          end else begin
            check("high_phase_len", run, HALF);
            check("hold_stable", longint'(hold_bad), 0);
            hold_bad = 1'b0;
            ref_bit  = sdata_o;
          end
          run = 1;
        end else begin
          run++;
        end
        if (sclk_o && sdata_o != hi_bit) hold_bad = 1'b1;
        if (nbits == N && !sclk_o) check("ack_sdata", longint'(sdata_o), 0);
        check("busy_in_frame", longint'(busy_o), 1);
        check("no_pulse_in_frame", longint'(done_o | err_o), 0);
      end else begin
        if (prev_frame) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            logic [N-1:0] eb;
            int           el;
            bit           ee;
            eb = exp_q.pop_front();
            el = exp_len_q.pop_front();
            ee = exp_err_q.pop_front();
            check("frame_bits", longint'(got_bits), longint'(eb));
            check("frame_nbits", nbits, N);
            check("frame_len", flen, el);
            check("done_pulse", longint'(done_o), longint'(!ee));
            check("err_pulse", longint'(err_o), longint'(ee));
          end
        end else begin
          check("no_pulse_idle", longint'(done_o | err_o), 0);
        end
        check("idle_outputs", longint'({sclk_o, sdata_o, busy_o}), 0);
      end
      prev_frame = frame_o;
      prev_sclk  = sclk_o;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_ni = 1'b0;
    send_i   = 1'b1;
    ack_i    = 1'b1;
    data_i   = DW'($urandom);
    flags_i  = FW'($urandom);
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    send_i   = 1'b0;
    reset_ni = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("after_reset");
    ack_i = 1'b0;

    send_frame(16'h0027, 4'h0, 3, 1'b0);
    send_frame(16'hFFFD, 4'hA, 1, 1'b0);      // back-to-back
    idle_cycles(2);
    send_frame(DW'($urandom), FW'($urandom), 0, 1'b0);       // timeout
    send_frame(DW'($urandom), FW'($urandom), ACK_TO, 1'b0);  // ack on last edge
    idle_cycles(1);
    send_frame(DW'($urandom), FW'($urandom), 2, 1'b1);       // noise mid-frame
    idle_cycles(1);
    reset_mid_frame();
    send_frame(16'h0001, 4'h0, 1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      send_frame(DW'($urandom), FW'($urandom), $urandom_range(0, ACK_TO),
                 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
